// File: rtl/kseq_pkg.sv
// Shared definitions for the kernel sequencer: FSM states, control-word
// bit positions and the RAM read latency the drain phase must cover.
package kseq_pkg;

    // Read latency of the weight/activation RAM feeding the accumulator.
    localparam int RAM_READ_LATENCY = 2;

    // Drain must outlast the RAM pipeline so the last tap's data lands.
    localparam int DRAIN_CYCLES = RAM_READ_LATENCY + 1;

    // Control word layout.
    localparam int VALID_BIT = 0;
    localparam int IDX_LSB   = 1;
    localparam int IDX_MSB   = 7;
    localparam int MARK_BIT  = 8;
    localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } kseq_state_t;

endpackage

// File: rtl/nested_counter.sv
// Tap counter nested inside a window counter. Lengths are latched on load;
// each enabled cycle advances the tap, rolling into the next window.
module nested_counter #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic [LEN_WIDTH-1:0] kernel_len,
    input  logic [LEN_WIDTH-1:0] num_windows,
    output logic [LEN_WIDTH-1:0] tap_idx,
    output logic                 last_tap,
    output logic                 last_window
);

    logic [LEN_WIDTH-1:0] r_klen;
    logic [LEN_WIDTH-1:0] r_nwin;
    logic [LEN_WIDTH-1:0] r_tap;
    logic [LEN_WIDTH-1:0] r_win;

    // Latch lengths on load, then step tap/window on each enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_klen <= '0;
            r_nwin <= '0;
            r_tap  <= '0;
            r_win  <= '0;
        end else if (load) begin
            r_klen <= kernel_len;
            r_nwin <= num_windows;
            r_tap  <= '0;
            r_win  <= '0;
        end else if (en) begin
            if (last_tap) begin
                r_tap <= '0;
                r_win <= last_window ? '0 : r_win + LEN_WIDTH'(1);
            end else begin
                r_tap <= r_tap + LEN_WIDTH'(1);
            end
        end
    end

    assign tap_idx     = r_tap;
    assign last_tap    = (r_tap == r_klen - LEN_WIDTH'(1));
    assign last_window = (r_win == r_nwin - LEN_WIDTH'(1));

endmodule

// File: rtl/kernel_sequencer.sv
// Kernel sequencer: walks num_windows windows of kernel_len taps each,
// issuing one accumulator control word plus RAM read address per tap,
// then drains the RAM pipeline and pulses done.
module kernel_sequencer
    import kseq_pkg::*;
#(
    parameter int CTRL_WIDTH = 9,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  kernel_len,
    input  logic [LEN_WIDTH-1:0]  num_windows,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  stall,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    kseq_state_t           r_state;
    kseq_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic [LEN_WIDTH-1:0]  w_tap_idx;
    logic                  w_last_tap;
    logic                  w_last_window;
    logic                  w_zero_len;
    logic                  w_accept;
    logic                  w_issue;

    // A zero-length job completes immediately without touching the counters.
    assign w_zero_len = (kernel_len == '0) || (num_windows == '0);
    assign w_accept   = (r_state == ST_IDLE) && start && !w_zero_len;
    // Stall gates the issue combinationally so a stalled tap is deferred.
    assign w_issue    = (r_state == ST_RUN) && !stall;

    nested_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load        (w_accept),
        .en          (w_issue),
        .kernel_len  (kernel_len),
        .num_windows (num_windows),
        .tap_idx     (w_tap_idx),
        .last_tap    (w_last_tap),
        .last_window (w_last_window)
    );

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and outputs; ctrl is only nonzero on an issued tap.
    always_comb begin
        w_state_nxt = r_state;
        ctrl        = '0;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = w_zero_len ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_issue) begin
                    ctrl[VALID_BIT]       = 1'b1;
                    ctrl[MARK_BIT]        = (w_tap_idx == '0);
                    ctrl[IDX_MSB:IDX_LSB] = IDX_W'(w_tap_idx);
                    if (w_last_tap && w_last_window) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Drain timer restarts from zero every time DRAIN is entered.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_DRAIN) r_drain_cnt <= '0;
        else                            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
    end

    // Read address: loaded with base on accept, advances per issued tap, wraps.
    always_ff @(posedge clk) begin
        if (rst)          r_rd_addr <= '0;
        else if (w_accept) r_rd_addr <= base_addr;
        else if (w_issue)  r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
    end

    assign rd_addr = r_rd_addr;

endmodule
